mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_if.sv | 47 ++++
 rtl/mem_access.sv | 191 +++++++++++++++++++
 tb/tb_mem_access.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Bundle of the mem_access stage's upstream, data-bus and writeback signals.
// Latency: none, wires only.
// Backpressure: in_ready from the stage; dresp_data_ok completes a bus access.
interface mem_access_if;
    // upstream (execute) side
    logic        in_valid;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [1:0]  in_memop;
    logic [1:0]  in_msize;
    logic        in_unsigned;
    logic [4:0]  in_rd;
    logic        flush;
    logic        in_ready;
    // data-bus request
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    // data-bus response
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    // writeback side
    logic        out_valid;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_misalign;

    // the memory stage itself
    modport slave (
        input  in_valid, in_addr, in_wdata, in_memop, in_msize, in_unsigned, in_rd, flush,
        input  dresp_data_ok, dresp_data,
        output in_ready,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output out_valid, out_result, out_rd, out_misalign
    );

    // the environment driving the stage (pipeline + data bus)
    modport master (
        output in_valid, in_addr, in_wdata, in_memop, in_msize, in_unsigned, in_rd, flush,
        output dresp_data_ok, dresp_data,
        input  in_ready,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  out_valid, out_result, out_rd, out_misalign
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: pass-through, aligned loads/stores over dbus, misalign trap.
// Latency: 1 cycle for pass-through/misalign; 1 cycle after dresp_data_ok for bus accesses.
// Backpressure: in_ready only in IDLE; bus request held stable until dresp_data_ok.
module mem_access #(
    parameter bit MISALIGN_CHECK = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    mem_access_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [1:0] MEMOP_LOAD  = 2'b01;
    localparam logic [1:0] MEMOP_STORE = 2'b10;

    state_t      r_state;
    state_t      w_state_nxt;

    // access latched when the request is issued
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [1:0]  r_msize;
    logic        r_unsigned;
    logic [4:0]  r_rd;
    logic        r_is_store;

    // registered writeback outputs
    logic        r_out_valid;
    logic [63:0] r_out_result;
    logic [4:0]  r_out_rd;
    logic        r_out_misalign;

    logic        w_out_valid_nxt;
    logic [63:0] w_out_result_nxt;
    logic [4:0]  w_out_rd_nxt;
    logic        w_out_misalign_nxt;

    logic        w_accept;
    logic        w_is_mem;
    logic [2:0]  w_size_mask;
    logic        w_misalign_hit;
    logic        w_issue;
    logic [63:0] w_lane;
    logic [63:0] w_load_result;
    logic [7:0]  w_byte_mask;
    logic [5:0]  w_bit_shift;

    // decode of the incoming instruction: acceptance, access kind and alignment
    always_comb begin
        w_accept = (r_state == ST_IDLE) && bus.in_valid && !bus.flush;
        w_is_mem = (bus.in_memop == MEMOP_LOAD) || (bus.in_memop == MEMOP_STORE);
        case (bus.in_msize)
            2'd0:    w_size_mask = 3'b000;
            2'd1:    w_size_mask = 3'b001;
            2'd2:    w_size_mask = 3'b011;
            default: w_size_mask = 3'b111;
        endcase
        w_misalign_hit = MISALIGN_CHECK && ((bus.in_addr[2:0] & w_size_mask) != 3'b000);
        w_issue        = w_accept && w_is_mem && !w_misalign_hit;
    end

    // load data: pick the addressed lane, then truncate and extend to 64 bits
    always_comb begin
        w_bit_shift = {r_addr[2:0], 3'b000};
        w_lane      = bus.dresp_data >> w_bit_shift;
        case (r_msize)
            2'd0:    w_load_result = r_unsigned ? {56'd0, w_lane[7:0]}
                                                : {{56{w_lane[7]}}, w_lane[7:0]};
            2'd1:    w_load_result = r_unsigned ? {48'd0, w_lane[15:0]}
                                                : {{48{w_lane[15]}}, w_lane[15:0]};
            2'd2:    w_load_result = r_unsigned ? {32'd0, w_lane[31:0]}
                                                : {{32{w_lane[31]}}, w_lane[31:0]};
            default: w_load_result = w_lane;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next state and next writeback values; a flushed access still waits for its data_ok
    always_comb begin
        w_state_nxt        = r_state;
        w_out_valid_nxt    = 1'b0;
        w_out_result_nxt   = r_out_result;
        w_out_rd_nxt       = r_out_rd;
        w_out_misalign_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = ST_WAIT;
                end else if (w_accept) begin
                    // pass-through, reserved memop, or trapped misaligned access
                    w_out_valid_nxt    = 1'b1;
                    w_out_result_nxt   = bus.in_addr;
                    w_out_rd_nxt       = bus.in_rd;
                    w_out_misalign_nxt = w_is_mem;
                end
            end
            ST_WAIT: begin
                if (bus.dresp_data_ok) begin
                    w_state_nxt = ST_IDLE;
                    if (!bus.flush) begin
                        w_out_valid_nxt  = 1'b1;
                        w_out_result_nxt = r_is_store ? 64'd0 : w_load_result;
                        w_out_rd_nxt     = r_is_store ? 5'd0 : r_rd;
                    end
                end else if (bus.flush) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.dresp_data_ok) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // capture the access parameters when a bus request is issued
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= 64'd0;
            r_wdata    <= 64'd0;
            r_msize    <= 2'd0;
            r_unsigned <= 1'b0;
            r_rd       <= 5'd0;
            r_is_store <= 1'b0;
        end else if (w_issue) begin
            r_addr     <= bus.in_addr;
            r_wdata    <= bus.in_wdata;
            r_msize    <= bus.in_msize;
            r_unsigned <= bus.in_unsigned;
            r_rd       <= bus.in_rd;
            r_is_store <= (bus.in_memop == MEMOP_STORE);
        end
    end

    // writeback output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_out_result   <= 64'd0;
            r_out_rd       <= 5'd0;
            r_out_misalign <= 1'b0;
        end else begin
            r_out_valid    <= w_out_valid_nxt;
            r_out_result   <= w_out_result_nxt;
            r_out_rd       <= w_out_rd_nxt;
            r_out_misalign <= w_out_misalign_nxt;
        end
    end

    // bus request is a pure function of the latched access, so it stays stable in WAIT/DRAIN
    always_comb begin
        case (r_msize)
            2'd0:    w_byte_mask = 8'h01;
            2'd1:    w_byte_mask = 8'h03;
            2'd2:    w_byte_mask = 8'h0F;
            default: w_byte_mask = 8'hFF;
        endcase
        bus.dreq_valid  = (r_state != ST_IDLE);
        bus.dreq_addr   = {r_addr[63:3], 3'b000};
        bus.dreq_size   = {1'b0, r_msize};
        bus.dreq_strobe = (bus.dreq_valid && r_is_store) ? (w_byte_mask << r_addr[2:0]) : 8'h00;
        bus.dreq_data   = r_is_store ? (r_wdata << w_bit_shift) : 64'd0;
    end

    // upstream handshake and writeback outputs
    always_comb begin
        bus.in_ready     = (r_state == ST_IDLE);
        bus.out_valid    = r_out_valid;
        bus.out_result   = r_out_result;
        bus.out_rd       = r_out_rd;
        bus.out_misalign = r_out_misalign;
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases then randomized transactions.
// Inputs are driven 1 time unit after the rising edge; outputs sampled at the same point.
// Expected values come from an arithmetic reference model of the access rules.
module tb_mem_access;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    mem_access_if bus ();

    mem_access #(.MISALIGN_CHECK(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference load result: select lane, keep size bytes, extend
    function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int sh,
                                             input int nb, input bit uns);
        logic [63:0] v;
        logic [63:0] m;
        int          bits;
        v    = rdata >> (8 * sh);
        bits = 8 * nb;
        if (bits < 64) begin
            m = (64'd1 << bits) - 64'd1;
            v = v & m;
            if (!uns && v[bits-1]) v = v | ~m;
        end
        return v;
    endfunction

    // one instruction through the stage; flush_at < 0 means no flush during WAIT
    task automatic run_txn(input logic [1:0] memop, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [1:0] msize,
                           input bit uns, input logic [4:0] rd, input int delay,
                           input int flush_at, input logic [63:0] rdata);
        int          nb;
        int          sh;
        bit          is_mem;
        bit          is_store;
        bit          mis;
        bit          flushed;
        logic [63:0] exp_addr;
        logic [63:0] exp_data;
        logic [15:0] wide_strobe;
        logic [7:0]  exp_strobe;
        nb       = 1 << msize;
        sh       = int'(addr % 8);
        is_mem   = (memop == 2'b01) || (memop == 2'b10);
        is_store = (memop == 2'b10);
        mis      = (addr % nb) != 0;
        flushed  = 1'b0;

        chk("ready_before", 64'(bus.in_ready), 64'd1);
        bus.in_valid    = 1'b1;
        bus.in_memop    = memop;
        bus.in_addr     = addr;
        bus.in_wdata    = wdata;
        bus.in_msize    = msize;
        bus.in_unsigned = uns;
        bus.in_rd       = rd;
        step();
        bus.in_valid = 1'b0;
        bus.in_memop = 2'b00;
        bus.in_addr  = {$urandom, $urandom};

        if (!is_mem || mis) begin
            chk("imm_valid", 64'(bus.out_valid), 64'd1);
            chk("imm_result", bus.out_result, addr);
            chk("imm_misalign", 64'(bus.out_misalign), 64'(is_mem));
            if (!is_mem) chk("imm_rd", 64'(bus.out_rd), 64'(rd));
            chk("imm_no_dreq", 64'(bus.dreq_valid), 64'd0);
            step();
            chk("imm_one_cycle", 64'(bus.out_valid), 64'd0);
            chk("imm_no_dreq2", 64'(bus.dreq_valid), 64'd0);
        end else begin
            exp_addr    = addr - (addr % 8);
            wide_strobe = 16'(((1 << nb) - 1) << sh);
            exp_strobe  = is_store ? wide_strobe[7:0] : 8'h00;
            exp_data    = wdata << (8 * sh);
            for (int i = 0; i < delay; i++) begin
                chk("req_valid", 64'(bus.dreq_valid), 64'd1);
                chk("req_addr", bus.dreq_addr, exp_addr);
                chk("req_size", 64'(bus.dreq_size), 64'(msize));
                chk("req_strobe", 64'(bus.dreq_strobe), 64'(exp_strobe));
                if (is_store) chk("req_data", bus.dreq_data, exp_data);
                chk("wait_no_out", 64'(bus.out_valid), 64'd0);
                chk("wait_not_ready", 64'(bus.in_ready), 64'd0);
                if (i == delay - 1) begin
                    bus.dresp_data_ok = 1'b1;
                    bus.dresp_data    = rdata;
                end
                if (i == flush_at) begin
                    bus.flush = 1'b1;
                    flushed   = 1'b1;
                end
                step();
                bus.dresp_data_ok = 1'b0;
                bus.flush         = 1'b0;
                bus.dresp_data    = {$urandom, $urandom};
            end
            chk("done_dreq_low", 64'(bus.dreq_valid), 64'd0);
            chk("done_valid", 64'(bus.out_valid), 64'(!flushed));
            if (!flushed) begin
                chk("done_misalign", 64'(bus.out_misalign), 64'd0);
                chk("done_result", bus.out_result,
                    is_store ? 64'd0 : ref_load(rdata, sh, nb, uns));
                chk("done_rd", 64'(bus.out_rd), is_store ? 64'd0 : 64'(rd));
            end
            step();
            chk("done_one_cycle", 64'(bus.out_valid), 64'd0);
            chk("done_ready", 64'(bus.in_ready), 64'd1);
        end
    endtask

    initial begin
        n_assert          = 0;
        n_fail            = 0;
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_addr       = 64'd0;
        bus.in_wdata      = 64'd0;
        bus.in_memop      = 2'b00;
        bus.in_msize      = 2'd0;
        bus.in_unsigned   = 1'b0;
        bus.in_rd         = 5'd0;
        bus.flush         = 1'b0;
        bus.dresp_data_ok = 1'b0;
        bus.dresp_data    = 64'd0;

        // reset state
        step();
        step();
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_dreq_valid", 64'(bus.dreq_valid), 64'd0);
        chk("rst_strobe", 64'(bus.dreq_strobe), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_misalign", 64'(bus.out_misalign), 64'd0);
        chk("rst_result", bus.out_result, 64'd0);
        chk("rst_rd", 64'(bus.out_rd), 64'd0);
        reset = 1'b0;
        step();

        // pass-through and reserved memop
        run_txn(2'b00, 64'h1234, 64'd0, 2'd0, 1'b0, 5'd5, 1, -1, 64'd0);
        run_txn(2'b11, 64'hDEAD_0000_0001_0007, 64'd0, 2'd3, 1'b0, 5'd9, 1, -1, 64'd0);
        // signed byte load, data_ok on the third request cycle
        run_txn(2'b01, 64'h1003, 64'd0, 2'd0, 1'b0, 5'd3, 3, -1, 64'h0000_0000_8000_0000);
        // half store in the top lane
        run_txn(2'b10, 64'h2006, 64'hBEEF, 2'd1, 1'b0, 5'd7, 2, -1, 64'd0);
        // misaligned word load
        run_txn(2'b01, 64'h3002, 64'd0, 2'd2, 1'b0, 5'd4, 1, -1, 64'd0);
        // unsigned word load from the upper lane
        run_txn(2'b01, 64'h4004, 64'd0, 2'd2, 1'b1, 5'd11, 1, -1, 64'h8765_4321_0000_0000);
        // flush in WAIT, data_ok two cycles later
        run_txn(2'b01, 64'h5000, 64'd0, 2'd3, 1'b0, 5'd6, 3, 0, 64'h1111_2222_3333_4444);
        // flush together with data_ok
        run_txn(2'b10, 64'h6008, 64'h55, 2'd0, 1'b0, 5'd8, 2, 1, 64'd0);

        // flush while presenting in IDLE: nothing accepted
        bus.in_valid = 1'b1;
        bus.in_memop = 2'b00;
        bus.in_addr  = 64'h77;
        bus.in_rd    = 5'd2;
        bus.flush    = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        chk("idle_flush_no_out", 64'(bus.out_valid), 64'd0);
        chk("idle_flush_no_dreq", 64'(bus.dreq_valid), 64'd0);

        // stray data_ok in IDLE
        bus.dresp_data_ok = 1'b1;
        step();
        bus.dresp_data_ok = 1'b0;
        chk("stray_ok_no_out", 64'(bus.out_valid), 64'd0);
        chk("stray_ok_ready", 64'(bus.in_ready), 64'd1);

        // reset while waiting on the bus
        bus.in_valid = 1'b1;
        bus.in_memop = 2'b10;
        bus.in_addr  = 64'h7000;
        bus.in_msize = 2'd3;
        bus.in_wdata = 64'hCAFE;
        step();
        bus.in_valid = 1'b0;
        bus.in_memop = 2'b00;
        chk("rstwait_dreq_on", 64'(bus.dreq_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstwait_dreq_off", 64'(bus.dreq_valid), 64'd0);
        chk("rstwait_strobe", 64'(bus.dreq_strobe), 64'd0);
        chk("rstwait_ready", 64'(bus.in_ready), 64'd1);
        chk("rstwait_no_out", 64'(bus.out_valid), 64'd0);
        bus.dresp_data_ok = 1'b1;
        step();
        bus.dresp_data_ok = 1'b0;
        chk("rstwait_late_ok", 64'(bus.out_valid), 64'd0);
        chk("rstwait_late_dreq", 64'(bus.dreq_valid), 64'd0);

        // randomized transactions
        for (int t = 0; t < 60; t++) begin
            logic [1:0]  r_op;
            logic [1:0]  r_sz;
            logic [63:0] r_a;
            int          r_dly;
            int          r_fl;
            r_op  = 2'($urandom_range(0, 3));
            r_sz  = 2'($urandom_range(0, 3));
            r_a   = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) r_a = r_a & ~((64'd1 << r_sz) - 64'd1);
            r_dly = $urandom_range(1, 4);
            r_fl  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, r_dly - 1) : -1;
            run_txn(r_op, r_a, {$urandom, $urandom}, r_sz, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), r_dly, r_fl, {$urandom, $urandom});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
